// File: rtl/execute_mod.sv
// Execute stage of the five-stage RISC-V pipeline: operand forwarding, ALU,
// BEQ resolution and branch target, plus the EX/MEM pipeline register.
module execute_mod (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegwriteE,
  input  logic        ALUsrcE,
  input  logic        MemwriteE,
  input  logic        ResultsrcE,
  input  logic        BranchE,
  input  logic [2:0]  ALUcontrolE,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCplus4E,
  input  logic [31:0] ImmextE,
  input  logic [4:0]  RdE,
  input  logic [31:0] ResultW,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegwriteM,
  output logic        MemwriteM,
  output logic        ResultsrcM,
  output logic [4:0]  RdM,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCplus4M
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;

  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] write_data_e;
  logic [31:0] alu_result;
  logic        zero_e;

  logic        regwrite_m_q,   regwrite_m_d;
  logic        memwrite_m_q,   memwrite_m_d;
  logic        resultsrc_m_q,  resultsrc_m_d;
  logic [4:0]  rd_m_q,         rd_m_d;
  logic [31:0] alu_result_m_q, alu_result_m_d;
  logic [31:0] write_data_m_q, write_data_m_d;
  logic [31:0] pc_plus4_m_q,   pc_plus4_m_d;

  // Select 2'b10 feeds back this stage's own registered result so a
  // back-to-back dependency resolves without a stall.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    src_a = RD1E;
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = alu_result_m_q;
      default: src_a = RD1E;
    endcase

    write_data_e = RD2E;
    case (ForwardBE)
      2'b01:   write_data_e = ResultW;
      2'b10:   write_data_e = alu_result_m_q;
      default: write_data_e = RD2E;
    endcase

    src_b = ALUsrcE ? ImmextE : write_data_e;
  end

  always_comb begin
    alu_result = 32'h0;
    case (ALUcontrolE)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLL: alu_result = src_a << src_b[4:0];
      ALU_SLT: alu_result = {31'b0, ($signed(src_a) < $signed(src_b))};
      ALU_XOR: alu_result = src_a ^ src_b;
      default: alu_result = 32'h0;
    endcase
  end

  assign zero_e    = (alu_result == 32'h0);
  assign PCSrcE    = BranchE & zero_e;
  assign PCTargetE = PCE + ImmextE;

  // No enable or flush: bubbles arrive from decode as zeroed controls.
  always_comb begin
    regwrite_m_d   = RegwriteE;
    memwrite_m_d   = MemwriteE;
    resultsrc_m_d  = ResultsrcE;
    rd_m_d         = RdE;
    alu_result_m_d = alu_result;
    write_data_m_d = write_data_e;
    pc_plus4_m_d   = PCplus4E;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_m_q   <= 1'b0;
      memwrite_m_q   <= 1'b0;
      resultsrc_m_q  <= 1'b0;
      rd_m_q         <= 5'd0;
      alu_result_m_q <= 32'h0;
      write_data_m_q <= 32'h0;
      pc_plus4_m_q   <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      regwrite_m_q   <= regwrite_m_d;
      memwrite_m_q   <= memwrite_m_d;
      resultsrc_m_q  <= resultsrc_m_d;
      rd_m_q         <= rd_m_d;
      alu_result_m_q <= alu_result_m_d;
      write_data_m_q <= write_data_m_d;
      pc_plus4_m_q   <= pc_plus4_m_d;
    end
  end

  assign RegwriteM  = regwrite_m_q;
  assign MemwriteM  = memwrite_m_q;
  assign ResultsrcM = resultsrc_m_q;
  assign RdM        = rd_m_q;
  assign ALUResultM = alu_result_m_q;
  assign WriteDataM = write_data_m_q;
  assign PCplus4M   = pc_plus4_m_q;

endmodule

// File: tb/tb_execute_mod.sv
// Scoreboard bench for execute_mod: stimulus pushes expected EX/MEM contents,
// a monitor pops and compares one cycle later; branch outputs checked inline.
module tb_execute_mod;

  typedef struct packed {
    logic        regw;
    logic        alusrc;
    logic        memw;
    logic        ressrc;
    logic        branch;
    logic [2:0]  ctl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] resw;
    logic [1:0]  fa;
    logic [1:0]  fb;
  } instr_t;

  typedef struct packed {
    logic        regw;
    logic        memw;
    logic        ressrc;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RegwriteE = 0, ALUsrcE = 0, MemwriteE = 0, ResultsrcE = 0, BranchE = 0;
  logic [2:0]  ALUcontrolE = 0;
  logic [31:0] RD1E = 0, RD2E = 0, PCE = 0, PCplus4E = 0, ImmextE = 0, ResultW = 0;
  logic [4:0]  RdE = 0;
  logic [1:0]  ForwardAE = 0, ForwardBE = 0;
  logic        PCSrcE, RegwriteM, MemwriteM, ResultsrcM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCplus4M;
  logic [4:0]  RdM;

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];
  logic [31:0] last_alu = 32'h0;  // what the model says ALUResultM holds now

  execute_mod dut (
    .clk(clk), .rst(rst),
    .RegwriteE(RegwriteE), .ALUsrcE(ALUsrcE), .MemwriteE(MemwriteE),
    .ResultsrcE(ResultsrcE), .BranchE(BranchE), .ALUcontrolE(ALUcontrolE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCplus4E(PCplus4E), .ImmextE(ImmextE),
    .RdE(RdE), .ResultW(ResultW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegwriteM(RegwriteM), .MemwriteM(MemwriteM), .ResultsrcM(ResultsrcM),
    .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCplus4M(PCplus4M)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] reg_val,
                                      input logic [31:0] resw);
    if (sel == 2'd1)      return resw;
    else if (sel == 2'd2) return last_alu;
    else                  return reg_val;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      3'd1: return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return 32'((64'(a) * (64'd1 << b[4:0])) % 64'h1_0000_0000);
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic instr_t mk(input logic [2:0] ctl, input logic [31:0] rd1,
                                input logic [31:0] rd2);
    instr_t t;
    t = '0;
    t.ctl = ctl;
    t.rd1 = rd1;
    t.rd2 = rd2;
    return t;
  endfunction

  // Drive one ID/EX instruction (caller aligns to negedge), check the
  // combinational branch outputs and queue the expected EX/MEM contents.
  task automatic apply(input instr_t t);
    logic [31:0] a, wd, b, res;
    exp_t e;
    RegwriteE = t.regw; ALUsrcE = t.alusrc; MemwriteE = t.memw;
    ResultsrcE = t.ressrc; BranchE = t.branch; ALUcontrolE = t.ctl;
    RD1E = t.rd1; RD2E = t.rd2; PCE = t.pc; PCplus4E = t.pc4; ImmextE = t.imm;
    RdE = t.rd; ResultW = t.resw; ForwardAE = t.fa; ForwardBE = t.fb;
    a   = fwd(t.fa, t.rd1, t.resw);
    wd  = fwd(t.fb, t.rd2, t.resw);
    b   = t.alusrc ? t.imm : wd;
    res = alu_ref(t.ctl, a, b);
    #1;
    check("pcsrc", {31'b0, PCSrcE}, {31'b0, (t.branch && res == 32'd0)});
    check("pctarget", PCTargetE, 32'((64'(t.pc) + 64'(t.imm)) % 64'h1_0000_0000));
    if (rst) begin
      e = '{regw: t.regw, memw: t.memw, ressrc: t.ressrc, rd: t.rd,
            alu: res, wd: wd, pc4: t.pc4};
      exp_q.push_back(e);
      last_alu = res;
    end
  endtask

  task automatic check_m_zero();
    check("rst_regw",   {31'b0, RegwriteM},  32'd0);
    check("rst_memw",   {31'b0, MemwriteM},  32'd0);
    check("rst_ressrc", {31'b0, ResultsrcM}, 32'd0);
    check("rst_rd",     {27'b0, RdM},        32'd0);
    check("rst_alu",    ALUResultM,          32'd0);
    check("rst_wd",     WriteDataM,          32'd0);
    check("rst_pc4",    PCplus4M,            32'd0);
  endtask

  // Monitor: the EX/MEM register updates every edge, so each queued entry
  // is compared just after the edge that captured it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("regw_m",   {31'b0, RegwriteM},  {31'b0, e.regw});
        check("memw_m",   {31'b0, MemwriteM},  {31'b0, e.memw});
        check("ressrc_m", {31'b0, ResultsrcM}, {31'b0, e.ressrc});
        check("rd_m",     {27'b0, RdM},        {27'b0, e.rd});
        check("alu_m",    ALUResultM,          e.alu);
        check("wd_m",     WriteDataM,          e.wd);
        check("pc4_m",    PCplus4M,            e.pc4);
      end
    end
  end

  initial begin
    instr_t t;
    logic [31:0] sweep_a, sweep_b;

    // Power-on reset
    #1 rst = 1'b0;
    #1 check_m_zero();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    t = mk(3'd0, 32'd3, 32'd4); t.regw = 1'b1; t.rd = 5'd5;
    apply(t);

    // ALU sweep with register operands
    sweep_a = 32'hFFFF_FFF0;
    sweep_b = 32'h0000_0010;
    for (int op = 0; op < 8; op++) begin
      @(negedge clk);
      t = mk(3'(op), sweep_a, sweep_b); t.rd = 5'(op + 1); t.pc4 = 32'(op * 4);
      apply(t);
    end

    // Immediate operand; store data still taken from RD2E
    @(negedge clk);
    t = mk(3'd0, 32'd100, 32'h1234_5678); t.alusrc = 1'b1; t.imm = 32'hFFFF_FFFF;
    apply(t);

    // Back-to-back forwarding from ALUResultM and ResultW
    @(negedge clk);
    t = mk(3'd0, 32'd5, 32'd6); t.regw = 1'b1;
    apply(t);
    @(negedge clk);
    t = mk(3'd0, 32'd77, 32'd88); t.fa = 2'b10; t.fb = 2'b01; t.resw = 32'd2;
    apply(t);

    // Both forwarded from ALUResultM with immediate SrcB
    @(negedge clk);
    t = mk(3'd0, 32'd1, 32'd2); t.fa = 2'b10; t.fb = 2'b10; t.alusrc = 1'b1; t.imm = 32'd7;
    apply(t);

    // Select 11 behaves as the register operand
    @(negedge clk);
    t = mk(3'd1, 32'd50, 32'd8); t.fa = 2'b11; t.fb = 2'b11; t.resw = 32'hAAAA_AAAA;
    apply(t);

    // Branch: taken, not taken, zero result without BranchE
    @(negedge clk);
    t = mk(3'd1, 32'd42, 32'd42); t.branch = 1'b1; t.pc = 32'h100; t.imm = 32'hFFFF_FFF8;
    apply(t);
    @(negedge clk);
    t.rd2 = 32'd41;
    apply(t);
    @(negedge clk);
    t.rd2 = 32'd42; t.branch = 1'b0;
    apply(t);

    // Store address + data
    @(negedge clk);
    t = mk(3'd0, 32'h200, 32'hDEAD_BEEF); t.memw = 1'b1; t.alusrc = 1'b1; t.imm = 32'd8;
    apply(t);

    // Shift by zero passes SrcA
    @(negedge clk);
    t = mk(3'd4, 32'hCAFE_F00D, 32'h0000_0020);
    apply(t);

    // Asynchronous reset mid-stream with nonzero registered state
    @(negedge clk);
    t = mk(3'd3, 32'h0F0F_0000, 32'h0000_F0F0); t.regw = 1'b1; t.memw = 1'b1;
    t.ressrc = 1'b1; t.rd = 5'd31; t.pc4 = 32'h44;
    apply(t);
    @(negedge clk);
    apply(t);
    #1 rst = 1'b0;
    exp_q.delete();
    last_alu = 32'h0;
    #1 check_m_zero();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    t = mk(3'd0, 32'd9, 32'd5); t.fa = 2'b10;
    apply(t);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      t.regw   = 1'($urandom);
      t.alusrc = 1'($urandom);
      t.memw   = 1'($urandom);
      t.ressrc = 1'($urandom);
      t.branch = 1'($urandom);
      t.ctl    = 3'($urandom);
      t.rd1    = $urandom;
      t.rd2    = ($urandom_range(0, 3) == 0) ? t.rd1 : $urandom;
      t.pc     = $urandom;
      t.pc4    = $urandom;
      t.imm    = ($urandom_range(0, 3) == 0) ? 32'(signed'($urandom_range(0, 63)) - 32) : $urandom;
      t.rd     = 5'($urandom);
      t.resw   = $urandom;
      t.fa     = 2'($urandom);
      t.fb     = 2'($urandom);
      apply(t);
    end

    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
